// File: rtl/scroll_text_display.sv
// scroll_text_display: multiplexed 7-segment text engine with a writable
// message buffer and static / scroll-left / scroll-right / blink modes.
module scroll_text_display #(
    parameter int         DIGITS     = 6,
    parameter int         MAX_LEN    = 16,
    parameter int         SCAN_DIV   = 65536,
    parameter int         SCROLL_DIV = 33554432,
    parameter logic [7:0] BLANK      = 8'hFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [$clog2(MAX_LEN)-1:0]   wr_addr,
    input  logic [7:0]                   wr_data,
    input  logic [$clog2(MAX_LEN+1)-1:0] msg_len,
    input  logic [1:0]                   mode,
    input  logic                         enable,
    output logic [7:0]                   seg,
    output logic [DIGITS-1:0]            sel,
    output logic                         step_tick
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int VW = $clog2(MAX_LEN + DIGITS + 1) + 1;
    localparam int DW = $clog2(DIGITS);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(SCROLL_DIV);

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(SCROLL_DIV - 1);
    localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);
    localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);

    typedef enum logic [1:0] {
        M_STATIC = 2'b00,
        M_LEFT   = 2'b01,
        M_RIGHT  = 2'b10,
        M_BLINK  = 2'b11
    } mode_e;

    logic [7:0]        buf_q [MAX_LEN];
    logic [CW-1:0]     scan_q;
    logic [SW-1:0]     step_q;
    logic [DW-1:0]     dig_q;
    logic [DW-1:0]     dig_nxt;
    logic [VW-1:0]     off_q;
    logic [VW-1:0]     off_d;
    logic              vis_q;
    logic              vis_d;
    logic [1:0]        mode_q;
    logic [DIGITS-1:0] sel_q;
    logic [7:0]        seg_q;
    logic [7:0]        load_val;
    logic [LW-1:0]     len_eff;
    logic [VW-1:0]     vlen;
    logic [VW-1:0]     pos_sum;
    logic [VW-1:0]     pos;
    logic              scan_end;
    logic              step_end;
    logic              mode_chg;
    logic              tick;
    logic              addr_ok;

    generate
        if (MAX_LEN == (1 << AW)) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_chk
            assign addr_ok = wr_addr < AW'(MAX_LEN);
        end
    endgenerate

    always_comb begin
        len_eff  = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
        vlen     = VW'(len_eff) + VW'(DIGITS);
        scan_end = scan_q == SCAN_LAST;
        step_end = step_q == STEP_LAST;
        mode_chg = mode != mode_q;
        tick     = step_end & enable & ~mode_chg & ~rst;
        dig_nxt  = (dig_q == DIG_LAST) ? '0 : dig_q + DW'(1);
    end

    // Position shown by the digit about to be selected; pre-step offset/phase.
    always_comb begin
        pos_sum  = off_q + VW'(DIGITS - 1) - VW'(dig_nxt);
        pos      = (pos_sum >= vlen) ? pos_sum - vlen : pos_sum;
        load_val = BLANK;
        if (vis_q && (pos < VW'(len_eff))) begin
            load_val = buf_q[pos[AW-1:0]];
        end
    end

    always_comb begin
        off_d = off_q;
        vis_d = vis_q;
        if (mode_chg) begin
            off_d = '0;
            vis_d = 1'b1;
        end else if (off_q >= vlen) begin
            off_d = '0;
        end else if (tick) begin
            case (mode_e'(mode))
                M_LEFT:  off_d = (off_q == vlen - VW'(1)) ? '0 : off_q + VW'(1);
                M_RIGHT: off_d = (off_q == '0) ? vlen - VW'(1) : off_q - VW'(1);
                M_BLINK: vis_d = ~vis_q;
                default: off_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q <= '0;
            step_q <= '0;
            dig_q  <= '0;
            off_q  <= '0;
            vis_q  <= 1'b1;
            mode_q <= mode;
            sel_q  <= DIGITS'(1);
            seg_q  <= BLANK;
            for (int i = 0; i < MAX_LEN; i++) begin
                buf_q[i] <= BLANK;
            end
        end else begin
            scan_q <= scan_end ? '0 : scan_q + CW'(1);
            step_q <= step_end ? '0 : step_q + SW'(1);
            off_q  <= off_d;
            vis_q  <= vis_d;
            mode_q <= mode;
            if (scan_end) begin
                dig_q <= dig_nxt;
                sel_q <= {sel_q[DIGITS-2:0], sel_q[DIGITS-1]};
                seg_q <= load_val;
            end
            if (wr_en && addr_ok) begin
                buf_q[wr_addr] <= wr_data;
            end
        end
    end

    assign seg       = seg_q;
    assign sel       = sel_q;
    assign step_tick = tick;

endmodule

// File: tb/tb_scroll_text_display.sv
// tb_scroll_text_display: randomized bench with a queue scoreboard fed by
// a cycle-level reference model of the scrolling text engine.
module tb_scroll_text_display;

    localparam int D  = 4;
    localparam int ML = 8;
    localparam int SD = 4;
    localparam int SC = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] msg_len;
    logic [1:0] mode;
    logic       enable;
    logic [7:0] seg;
    logic [3:0] sel;
    logic       step_tick;

    always #5 clk = ~clk;

    scroll_text_display #(
        .DIGITS(D), .MAX_LEN(ML), .SCAN_DIV(SD),
        .SCROLL_DIV(SC), .BLANK(8'hFF)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .msg_len(msg_len), .mode(mode),
        .enable(enable), .seg(seg), .sel(sel), .step_tick(step_tick)
    );

    typedef struct {
        int         edge_n;
        logic [7:0] seg;
        logic [3:0] sel;
    } load_t;

    load_t q_load[$];
    int    q_tick[$];
    int    compared   = 0;
    int    mismatched = 0;

    int         m_scan, m_step, m_off, m_dig, m_edges = 0;
    bit         m_vis, m_rst_edge, armed = 0;
    logic [1:0] m_pmode;
    logic [7:0] m_buf [ML];

    function automatic void chk(input string nm, input bit ok, input string info);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL %s: %s", nm, info);
        end
    endfunction

    // Reference model: virtual sequence = L message chars followed by D blanks.
    always @(posedge clk) begin : model
        int L, V, p;
        bit t;
        load_t e;
        m_edges++;
        m_rst_edge = rst;
        if (rst) begin
            m_scan = 0; m_step = 0; m_off = 0; m_dig = 0;
            m_vis = 1; m_pmode = mode; armed = 1;
            for (int i = 0; i < ML; i++) m_buf[i] = 8'hFF;
        end else begin
            L = (msg_len > ML) ? ML : int'(msg_len);
            V = L + D;
            if (m_scan == SD - 1) begin
                m_dig = (m_dig + 1) % D;
                p = (m_off + D - 1 - m_dig) % V;
                e.edge_n = m_edges;
                e.sel = 4'(1 << m_dig);
                e.seg = (!m_vis || p >= L) ? 8'hFF : m_buf[p];
                q_load.push_back(e);
            end
            t = (m_step == SC - 1) && enable && (mode == m_pmode);
            if (t) q_tick.push_back(m_edges);
            if (mode != m_pmode) begin
                m_off = 0; m_vis = 1;
            end else if (m_off >= V) begin
                m_off = 0;
            end else if (t) begin
                if (mode == 2'b01) m_off = (m_off + 1) % V;
                else if (mode == 2'b10) m_off = (m_off + V - 1) % V;
                else if (mode == 2'b11) m_vis = !m_vis;
            end
            if (wr_en) m_buf[wr_addr] = wr_data;
            m_scan = (m_scan + 1) % SD;
            m_step = (m_step + 1) % SC;
            m_pmode = mode;
        end
    end

    bit         tick_seen;
    logic [3:0] prev_sel;

    always @(negedge clk) begin
        #1;
        tick_seen = step_tick;
    end

    always @(posedge clk) begin : monitor
        bit exp_t;
        load_t e;
        #1;
        if (armed) begin
            if (m_rst_edge) begin
                chk("reset_out", seg === 8'hFF && sel === 4'b0001,
                    $sformatf("seg=%h sel=%b, want seg=ff sel=0001", seg, sel));
                chk("reset_tick", tick_seen == 1'b0,
                    $sformatf("step_tick=%0d, want 0", tick_seen));
            end else begin
                exp_t = q_tick.size() > 0 && q_tick[0] == m_edges;
                if (exp_t) void'(q_tick.pop_front());
                if (exp_t || tick_seen)
                    chk("step_tick", tick_seen == exp_t,
                        $sformatf("edge %0d tick=%0d, want %0d", m_edges, tick_seen, exp_t));
                if (q_load.size() > 0 || sel !== prev_sel) begin
                    if (q_load.size() == 0) begin
                        chk("load", 1'b0,
                            $sformatf("edge %0d sel %b->%b, want no change", m_edges, prev_sel, sel));
                    end else begin
                        e = q_load.pop_front();
                        chk("load", e.edge_n == m_edges && seg === e.seg && sel === e.sel,
                            $sformatf("edge %0d seg=%h sel=%b, want seg=%h sel=%b",
                                      m_edges, seg, sel, e.seg, e.sel));
                    end
                end
            end
            prev_sel = sel;
        end
    end

    task automatic wr(input int a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Length changes land away from digit loads and step edges.
    task automatic set_len(input int v);
        for (int i = 0; i < 8 && (m_scan == SD - 1 || m_step == SC - 1); i++)
            @(negedge clk);
        msg_len = 4'(v);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        msg_len = '0; mode = 2'b00; enable = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(20);

        wr(0, 8'h91); wr(1, 8'h61); wr(2, 8'hE3); wr(3, 8'h31);
        set_len(4);
        cycles(200);

        set_len(2);
        mode = 2'b01;
        cycles(SC * 7);

        mode = 2'b10;
        cycles(SC * 3);

        set_len(4);
        mode = 2'b11;
        cycles(SC * 3 + 10);
        for (int i = 0; i < 300 && m_vis; i++) @(negedge clk);
        cycles(5);
        enable = 1'b0;
        cycles(200);
        enable = 1'b1;
        cycles(SC * 2);

        mode = 2'b01;
        set_len(0);
        cycles(SC * 3);
        set_len(12);
        cycles(SC * 5);
        cycles(30);
        mode = 2'b00;
        cycles(40);
        mode = 2'b01;
        cycles(SC * 2 + 17);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(40);

        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 499) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom);
            wr_data = 8'($urandom);
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 99) == 0 && m_scan != SD - 1 && m_step != SC - 1)
                msg_len = 4'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; wr_en = 1'b0;
        cycles(8);

        chk("drain", q_load.size() == 0 && q_tick.size() == 0,
            $sformatf("%0d loads and %0d ticks outstanding, want 0 and 0",
                      q_load.size(), q_tick.size()));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
